// File: rtl/pim_out_readout_unit.sv
// PIM output readout: captures N_BANK ADC banks, subtracts a saturating zero-point
// at readout and drains packed BUS_W-bit words under a request/valid handshake.
module pim_out_readout_unit #(
  parameter int unsigned N_BANK = 2,
  parameter int unsigned LANES  = 128,
  parameter int unsigned ADC_W  = 8,
  parameter int unsigned BUS_W  = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_BANK*LANES*ADC_W-1:0]    bank_data_i,
  input  logic [N_BANK-1:0]                cap_en_i,
  input  logic                             zp_we_i,
  input  logic [ADC_W-1:0]                 zp_i,
  input  logic                             start_i,
  input  logic                             rd_req_i,
  output logic [BUS_W-1:0]                 rd_data_o,
  output logic                             rd_valid_o,
  output logic                             ready_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             ovf_o,
  output logic [$clog2(N_BANK*LANES*ADC_W/BUS_W):0] words_left_o
);

  localparam int unsigned LPW   = BUS_W / ADC_W;
  localparam int unsigned WPB   = LANES * ADC_W / BUS_W;
  localparam int unsigned NW    = N_BANK * WPB;
  localparam int unsigned PTR_W = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned WL_W  = $clog2(NW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [N_BANK-1:0]    bank_vld_q, bank_vld_d;
  logic [ADC_W-1:0]     zp_q, zp_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [WL_W-1:0]      words_left_q, words_left_d;
  logic [BUS_W-1:0]     rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;
  logic                 err;
  logic                 start_acc;
  logic [N_BANK-1:0]    cap_we;
  logic [BUS_W-1:0]     word_c;

  // Capture array held as readout words; word k already maps to bank k/WPB.
  logic [BUS_W-1:0]     cap_q [NW];

  // Per-lane saturating zero-point subtraction on the selected word.
  for (genvar j = 0; j < LPW; j++) begin : g_lane
    logic [ADC_W:0] diff;
    assign diff = {1'b0, cap_q[ptr_q][j*ADC_W +: ADC_W]} - {1'b0, zp_q};
    assign word_c[j*ADC_W +: ADC_W] = diff[ADC_W] ? '0 : diff[ADC_W-1:0];
  end

  assign start_acc = start_i && ready_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d      = state_q;
    bank_vld_d   = bank_vld_q;
    zp_d         = zp_q;
    ptr_d        = ptr_q;
    words_left_d = words_left_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    cap_we       = '0;
    err          = 1'b0;

    case (state_q)
      IDLE, ARMED: begin
        if (start_acc) begin
          state_d      = DRAIN;
          ptr_d        = '0;
          words_left_d = WL_W'(NW);
          ovf_d        = 1'b0;
          if (|cap_en_i) err = 1'b1;
        end else begin
          if (start_i) err = 1'b1;
          cap_we     = cap_en_i;
          bank_vld_d = bank_vld_q | cap_en_i;
          if (|cap_en_i) state_d = ARMED;
        end
        if (zp_we_i) zp_d = zp_i;
        if (rd_req_i) err = 1'b1;
      end
      DRAIN: begin
        if ((|cap_en_i) || zp_we_i || start_i) err = 1'b1;
        if (done_q) begin
          // Last word was delivered last cycle: release the banks.
          state_d    = IDLE;
          bank_vld_d = '0;
          if (rd_req_i) err = 1'b1;
        end else if (rd_req_i) begin
          rd_valid_d   = 1'b1;
          rd_data_d    = word_c;
          ptr_d        = ptr_q + PTR_W'(1);
          words_left_d = words_left_q - WL_W'(1);
          done_d       = (words_left_q == WL_W'(1));
        end
      end
      default: state_d = IDLE;
    endcase

    if (err) ovf_d = 1'b1;
  end

  assign ready_d = (&bank_vld_d) && (state_d != DRAIN);
  assign busy_d  = (state_d == DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bank_vld_q   <= '0;
      zp_q         <= '0;
      ptr_q        <= '0;
      words_left_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      bank_vld_q   <= bank_vld_d;
      zp_q         <= zp_d;
      ptr_q        <= ptr_d;
      words_left_q <= words_left_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  // Capture registers: a bank write loads its WPB contiguous words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned w = 0; w < NW; w++) cap_q[w] <= '0;
    end else begin
      for (int unsigned b = 0; b < N_BANK; b++) begin
        if (cap_we[b]) begin
          for (int unsigned w = 0; w < WPB; w++) begin
            cap_q[b*WPB + w] <= bank_data_i[(b*WPB + w)*BUS_W +: BUS_W];
          end
        end
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ovf_o        = ovf_q;
  assign words_left_o = words_left_q;

endmodule

// File: tb/tb_pim_out_readout_unit.sv
// Scoreboard bench for pim_out_readout_unit: expected words are queued on each
// request and compared when rd_valid_o appears.
module tb_pim_out_readout_unit;

  localparam int unsigned N_BANK = 2;
  localparam int unsigned LANES  = 128;
  localparam int unsigned ADC_W  = 8;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned LPW    = BUS_W / ADC_W;
  localparam int unsigned WPB    = LANES * ADC_W / BUS_W;
  localparam int unsigned NW     = N_BANK * WPB;
  localparam int unsigned WL_W   = $clog2(NW) + 1;

  logic                          clk;
  logic                          rst;
  logic [N_BANK*LANES*ADC_W-1:0] bank_data;
  logic [N_BANK-1:0]             cap_en;
  logic                          zp_we;
  logic [ADC_W-1:0]              zp;
  logic                          start;
  logic                          rd_req;
  logic [BUS_W-1:0]              rd_data;
  logic                          rd_valid;
  logic                          ready;
  logic                          busy;
  logic                          done;
  logic                          ovf;
  logic [WL_W-1:0]               words_left;

  pim_out_readout_unit #(
    .N_BANK(N_BANK), .LANES(LANES), .ADC_W(ADC_W), .BUS_W(BUS_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bank_data_i  (bank_data),
    .cap_en_i     (cap_en),
    .zp_we_i      (zp_we),
    .zp_i         (zp),
    .start_i      (start),
    .rd_req_i     (rd_req),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .ready_o      (ready),
    .busy_o       (busy),
    .done_o       (done),
    .ovf_o        (ovf),
    .words_left_o (words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic [ADC_W-1:0] bank_m [N_BANK][LANES];
  logic [ADC_W-1:0] zp_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BUS_W-1:0] model_word(input int k);
    logic [BUS_W-1:0] w;
    logic [ADC_W-1:0] raw;
    w = '0;
    for (int j = 0; j < LPW; j++) begin
      raw = bank_m[k / WPB][(k % WPB) * LPW + j];
      w[j*ADC_W +: ADC_W] = (raw >= zp_m) ? raw - zp_m : '0;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_banks();
    for (int b = 0; b < N_BANK; b++)
      for (int l = 0; l < LANES; l++)
        bank_data[(b*LANES + l)*ADC_W +: ADC_W] = bank_m[b][l];
  endtask

  task automatic capture(input logic [N_BANK-1:0] en);
    drive_banks();
    cap_en = en;
    tick();
    cap_en = '0;
  endtask

  task automatic load_zp(input logic [ADC_W-1:0] v);
    zp_m  = v;
    zp    = v;
    zp_we = 1'b1;
    tick();
    zp_we = 1'b0;
  endtask

  task automatic start_drain();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_words_left", words_left, NW);
    check_eq("start_ovf_clear", ovf, 0);
    check_eq("start_ready_low", ready, 0);
  endtask

  task automatic req_word(input int k, input logic [BUS_W-1:0] exp);
    rd_req = 1'b1;
    sb.push_back('{data: exp, last: (k == NW - 1)});
    tick();
    rd_req = 1'b0;
    check_eq("words_left", words_left, NW - k - 1);
  endtask

  task automatic end_of_drain();
    tick();
    check_eq("end_busy", busy, 0);
    check_eq("end_words_left", words_left, 0);
    check_eq("end_done_low", done, 0);
    check_eq("end_ready_low", ready, 0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rd_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", rd_valid, 0);
      end else begin
        e = sb.pop_front();
        check_eq("rd_data", rd_data, e.data);
        check_eq("done_with_word", done, e.last);
      end
    end
  end

  initial begin
    rst = 1'b1; bank_data = '0; cap_en = '0; zp_we = 1'b0; zp = '0;
    start = 1'b0; rd_req = 1'b0; zp_m = '0;
    tick();
    tick();
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_words_left", words_left, 0);
    rst = 1'b0;
    tick();

    // Ramp data, zero zero-point, back-to-back drain.
    for (int l = 0; l < LANES; l++) begin
      bank_m[0][l] = ADC_W'(l);
      bank_m[1][l] = ADC_W'(255 - l);
    end
    capture(2'b11);
    check_eq("t1_ready", ready, 1);
    start_drain();
    for (int k = 0; k < NW; k++)
      req_word(k, (k == 0) ? 32'h03020100 : (k == 32) ? 32'hFCFDFEFF : model_word(k));
    end_of_drain();

    // Saturating zero-point.
    load_zp(8'h10);
    for (int l = 0; l < LANES; l++) begin
      bank_m[0][l] = 8'h08;
      bank_m[1][l] = 8'h20;
    end
    capture(2'b11);
    start_drain();
    for (int k = 0; k < NW; k++)
      req_word(k, (k < int'(WPB)) ? 32'h00000000 : 32'h10101010);
    end_of_drain();

    // Partial capture, then start rejected.
    for (int b = 0; b < N_BANK; b++)
      for (int l = 0; l < LANES; l++) bank_m[b][l] = ADC_W'($urandom);
    load_zp(8'h40);
    capture(2'b01);
    check_eq("t3_ready_partial", ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t3_ovf", ovf, 1);
    check_eq("t3_ready", ready, 0);
    check_eq("t3_busy", busy, 0);
    capture(2'b10);
    check_eq("t3_ready_full", ready, 1);
    start_drain();

    // Mid-drain capture and zero-point write must not disturb the drain.
    for (int k = 0; k < 10; k++) req_word(k, model_word(k));
    bank_data = ~bank_data;
    cap_en    = 2'b11;
    zp        = 8'hAA;
    zp_we     = 1'b1;
    tick();
    cap_en = '0;
    zp_we  = 1'b0;
    check_eq("t4_ovf", ovf, 1);
    check_eq("t4_busy", busy, 1);
    check_eq("t4_words_left", words_left, NW - 10);
    for (int k = 10; k < NW; k++) req_word(k, model_word(k));
    end_of_drain();
    check_eq("t4_ovf_sticky", ovf, 1);

    // Gapped requests every third cycle.
    for (int b = 0; b < N_BANK; b++)
      for (int l = 0; l < LANES; l++) bank_m[b][l] = ADC_W'($urandom);
    zp_m = 8'h40;
    capture(2'b11);
    check_eq("t5_ovf_before_start", ovf, 1);
    start_drain();
    for (int k = 0; k < NW; k++) begin
      rd_req = 1'b1;
      sb.push_back('{data: model_word(k), last: (k == NW - 1)});
      tick();
      rd_req = 1'b0;
      check_eq("gap_valid", rd_valid, 1);
      tick();
      check_eq("gap_idle_valid", rd_valid, 0);
      check_eq("gap_hold", rd_data, model_word(k));
      tick();
      check_eq("gap_hold2", rd_data, model_word(k));
    end
    check_eq("t5_busy_end", busy, 0);
    check_eq("t5_words_left_end", words_left, 0);

    // Asynchronous reset mid-drain.
    load_zp(8'h00);
    for (int b = 0; b < N_BANK; b++)
      for (int l = 0; l < LANES; l++) bank_m[b][l] = ADC_W'($urandom);
    capture(2'b11);
    start_drain();
    for (int k = 0; k < 20; k++) req_word(k, model_word(k));
    rd_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rd_data", rd_data, 0);
    check_eq("arst_rd_valid", rd_valid, 0);
    check_eq("arst_ready", ready, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_ovf", ovf, 0);
    check_eq("arst_words_left", words_left, 0);
    rd_req = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_ready", ready, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check_eq("post_rst_no_valid", rd_valid, 0);
    check_eq("post_rst_ovf", ovf, 1);
    tick();
    check_eq("post_rst_no_valid2", rd_valid, 0);

    check_eq("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
